// File: rtl/uart_cmd_sender_pkg.sv
// Shared types and constants for the UART command sender.
// Holds the FSM encoding, the neutral command byte and the baud divisor calculation.
package uart_cmd_sender_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [7:0] CMD_IDLE = 8'h80;

  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_cmd_sender_if.sv
// Command-in / serial-out bundle between driving-mode logic, sender and board pin.
// The slave side is the sender; the master side is whoever supplies commands.
interface uart_cmd_sender_if;
  logic [7:0] cmd_in;
  logic       en;
  logic       tx;
  logic       busy;
  logic       sent_pulse;
  logic [7:0] last_sent;

  modport master (output cmd_in, en, input tx, busy, sent_pulse, last_sent);
  modport slave  (input cmd_in, en, output tx, busy, sent_pulse, last_sent);
endinterface

// File: rtl/uart_cmd_sender_baud_tick.sv
// Mod-DIV bit-period counter: tick on the last cycle of a bit, pre_tick one cycle earlier.
// Zero latency from count to tick; clr wins over en and restarts the bit period.
module uart_baud_tick #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic pre_tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == CW'(DIV - 1)) ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick     = en && (r_cnt == CW'(DIV - 1));
  assign pre_tick = en && (r_cnt == CW'(DIV - 2));

endmodule

// File: rtl/uart_cmd_sender.sv
// Sends the driving command as a UART 8N1 frame on change or on periodic refresh.
// tx falls one cycle after launch; frame is 10 bit periods; cmd_in is ignored while busy.
module uart_cmd_sender
  import uart_cmd_sender_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned BAUD           = 9600,
  parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_sender_if.slave bus
);
  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int unsigned REF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic               r_tx, w_tx_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_sent_pulse;
  logic [7:0]         r_last_sent;
  logic [7:0]         r_shift;
  logic [2:0]         r_idx, w_idx_nxt;
  logic [REF_W-1:0]   r_refresh;
  logic               w_tick, w_pre_tick;
  logic               w_launch, w_refresh_due;

  assign w_refresh_due = (r_refresh == REF_MAX);
  assign w_launch      = (r_state == S_IDLE) && bus.en &&
                         ((bus.cmd_in != r_last_sent) || w_refresh_due);

  // Clearing on every state change keeps each frame phase-aligned to its own start bit.
  uart_baud_tick #(.DIV(BAUD_DIV)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (r_state != w_state_nxt),
    .en       (r_state != S_IDLE),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: if (w_launch) begin
        w_state_nxt = S_START;
        w_tx_nxt    = 1'b0;
        w_busy_nxt  = 1'b1;
      end
      S_START: if (w_tick) begin
        w_state_nxt = S_DATA;
        w_idx_nxt   = 3'd0;
        w_tx_nxt    = r_shift[0];
      end
      S_DATA: if (w_tick) begin
        if (r_idx == 3'd7) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
          w_tx_nxt  = r_shift[r_idx + 3'd1];
        end
      end
      S_STOP: if (w_tick) begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_tx_nxt    = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_sent_pulse <= 1'b0;
      r_last_sent  <= 8'h00;
      r_shift      <= 8'h00;
      r_idx        <= 3'd0;
      r_refresh    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tx         <= w_tx_nxt;
      r_busy       <= w_busy_nxt;
      r_idx        <= w_idx_nxt;
      // Registered one cycle early so the strobe lands on the stop bit's final cycle.
      r_sent_pulse <= (r_state == S_STOP) && w_pre_tick;
      if (w_launch) begin
        r_shift     <= bus.cmd_in;
        r_last_sent <= bus.cmd_in;
        r_refresh   <= '0;
      end else if (!w_refresh_due) begin
        r_refresh <= r_refresh + REF_W'(1);
      end
    end
  end

  assign bus.tx         = r_tx;
  assign bus.busy       = r_busy;
  assign bus.sent_pulse = r_sent_pulse;
  assign bus.last_sent  = r_last_sent;

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Bench for uart_cmd_sender: directed command sequences, expected frames queued and
// checked by a serial-line monitor that decodes tx bit by bit.
module tb_uart_cmd_sender;
  import uart_cmd_sender_pkg::*;

  localparam int BD = 16;

  typedef struct {
    logic [7:0] b;
    int         s;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc;
  int   n_checks = 0;
  int   n_err    = 0;

  exp_t q[$];
  exp_t cur;
  logic mon_act = 1'b0;
  int   mon_f   = 0;
  logic prev_tx = 1'b1;
  logic [7:0] mon_byte = 8'h00;

  always #5 clk = ~clk;

  uart_cmd_sender_if bus();

  uart_cmd_sender #(
    .CLK_FREQ       (1600),
    .BAUD           (100),
    .REFRESH_CYCLES (400)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Serial-line monitor: bit k of a frame is sampled mid-period at rel = 16k+8.
  always @(negedge clk) begin
    int rel;
    if (!rst_n) begin
      mon_act = 1'b0;
      prev_tx = 1'b1;
    end else begin
      if (!mon_act && prev_tx && !bus.tx) begin
        mon_act  = 1'b1;
        mon_f    = cyc;
        mon_byte = 8'h00;
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_frame at cycle %0d: got a frame, want none", cyc);
          cur.b = 8'hxx;
          cur.s = -1;
        end else begin
          cur = q.pop_front();
          chk("frame_start_cycle", mon_f, cur.s);
        end
      end
      if (mon_act) begin
        rel = cyc - mon_f;
        if (rel % BD == BD / 2) begin
          if (rel / BD == 0)      chk("start_bit", {31'd0, bus.tx}, 0);
          else if (rel / BD <= 8) mon_byte[rel / BD - 1] = bus.tx;
          else                    chk("stop_bit", {31'd0, bus.tx}, 1);
        end
        if (rel == BD / 2) chk("busy_in_frame", {31'd0, bus.busy}, 1);
        if (rel == 10 * BD - 1) begin
          chk("sent_pulse", {31'd0, bus.sent_pulse}, 1);
          chk("frame_byte", {24'd0, mon_byte}, {24'd0, cur.b});
          chk("last_sent", {24'd0, bus.last_sent}, {24'd0, cur.b});
        end else if (bus.sent_pulse) begin
          chk("sent_pulse_stray", {31'd0, bus.sent_pulse}, 0);
        end
        if (rel == 10 * BD) begin
          chk("busy_after_frame", {31'd0, bus.busy}, 0);
          mon_act = 1'b0;
        end
      end else if (bus.sent_pulse) begin
        chk("sent_pulse_idle", {31'd0, bus.sent_pulse}, 0);
      end
      prev_tx = bus.tx;
    end
  end

  initial begin
    bus.cmd_in = CMD_IDLE;
    bus.en     = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, bus.tx}, 1);
    chk("reset_busy", {31'd0, bus.busy}, 0);
    chk("reset_sent_pulse", {31'd0, bus.sent_pulse}, 0);
    chk("reset_last_sent", {24'd0, bus.last_sent}, 0);

    // Neutral command goes out immediately since last_sent resets to 00.
    q.push_back('{b: CMD_IDLE, s: 1});
    rst_n = 1'b1;

    // Change during DATA must not corrupt frame 1; new byte follows after one idle cycle.
    wait_cyc(60);
    bus.cmd_in = 8'hA1;
    q.push_back('{b: 8'hA1, s: 162});

    // Held command is refreshed every 400 cycles.
    wait_cyc(325);
    bus.cmd_in = 8'hA5;
    for (int k = 0; k < 5; k++) q.push_back('{b: 8'hA5, s: 326 + 400 * k});

    // Disabled: command toggles must not produce frames.
    wait_cyc(2200);
    bus.en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) bus.cmd_in = ((i / 10) % 2 == 1) ? 8'h82 : 8'h81;
      @(negedge clk);
      chk("en_low_tx", {31'd0, bus.tx}, 1);
      chk("en_low_busy", {31'd0, bus.busy}, 0);
    end
    bus.cmd_in = 8'h82;
    q.push_back('{b: 8'h82, s: 2301});
    bus.en = 1'b1;
    wait_cyc(2301);
    chk("tx_fall_after_en", {31'd0, bus.tx}, 0);

    // Asynchronous reset in the middle of data bit 3 of that frame.
    wait_cyc(2372);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, bus.tx}, 1);
    chk("async_rst_busy", {31'd0, bus.busy}, 0);
    chk("async_rst_last_sent", {24'd0, bus.last_sent}, 0);
    chk("async_rst_sent_pulse", {31'd0, bus.sent_pulse}, 0);
    repeat (3) @(negedge clk);
    q.push_back('{b: 8'h82, s: 1});
    rst_n = 1'b1;

    wait_cyc(170);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
